xsleena_gfx_rom_responder: RTL and testbench

Serving end of the background-layer graphics ROM request interface. It accepts single-cycle `ROM_req` pulses with a 17-bit tile-line address from a tilemap layer, fetches the 16-bit word (high-plane byte in [15:8], low-plane byte in [7:0]) through a request/acknowledge SDRAM read port, and drives `ROM_data` back to the layer. The layer's shift-register load point is a fixed number of clocks after its request, so the responder must meet a bounded latency. It sits between one layer instance and one SDRAM arbiter port.

---
 rtl/xsleena_gfx_rom_responder_pkg.sv | 18 +
 rtl/xsleena_gfx_rom_responder_if.sv | 33 +++
 rtl/xsleena_req_slot.sv | 46 ++++
 rtl/xsleena_gfx_rom_responder.sv | 151 +++++++++++++++
 tb/tb_xsleena_gfx_rom_responder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/xsleena_gfx_rom_responder_pkg.sv
// Shared types and constants for the Xain'd Sleena graphics ROM responders.
// Holds the responder state encoding, the ROM word/address widths and the
// default SDRAM wait bound used by the layer and sprite responders.
package xsleena_rom_pkg;

  localparam int ROM_ADDR_W      = 17;
  localparam int ROM_DATA_W      = 16;
  localparam int ROM_TMO_W       = 5;
  localparam int ROM_TIMEOUT_DEF = 31;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_ISSUE,
    RSP_WAIT,
    RSP_DONE
  } rom_rsp_state_t;

endpackage

// File: rtl/xsleena_gfx_rom_responder_if.sv
// Bundle between a tilemap layer, the ROM responder and one SDRAM arbiter port.
// slave  : the responder (takes layer requests, drives SDRAM reads).
// master : the environment (layer + SDRAM arbiter).
// Signals: ROM_req/req_ROM_addr (layer request), ROM_data/rom_valid/rom_busy/
// rom_err (layer response/status), sdr_req/sdr_addr (read request),
// sdr_ack/sdr_rdy/sdr_dout (arbiter accept and read data).
interface xsleena_gfx_rom_responder_if
  import xsleena_rom_pkg::*;
#(
  parameter int SDR_AW = 24
);
  logic                  ROM_req;
  logic [ROM_ADDR_W-1:0] req_ROM_addr;
  logic [ROM_DATA_W-1:0] ROM_data;
  logic                  rom_valid;
  logic                  rom_busy;
  logic                  rom_err;
  logic                  sdr_req;
  logic [SDR_AW-1:0]     sdr_addr;
  logic                  sdr_ack;
  logic                  sdr_rdy;
  logic [ROM_DATA_W-1:0] sdr_dout;

  modport slave (
    input  ROM_req, req_ROM_addr, sdr_ack, sdr_rdy, sdr_dout,
    output ROM_data, rom_valid, rom_busy, rom_err, sdr_req, sdr_addr
  );

  modport master (
    output ROM_req, req_ROM_addr, sdr_ack, sdr_rdy, sdr_dout,
    input  ROM_data, rom_valid, rom_busy, rom_err, sdr_req, sdr_addr
  );
endinterface

// File: rtl/xsleena_req_slot.sv
// One-entry, newest-wins request address holder.
// Ports: clk/rst (async active-high), push_i/push_addr_i (store request),
// cmp_addr_i (address already in flight; matching pushes are dropped),
// pop_i (consume entry), valid_o/addr_o (held entry).
module xsleena_req_slot
  import xsleena_rom_pkg::*;
#(
  parameter int AW = ROM_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [AW-1:0] cmp_addr_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o
);
  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    // A fresh push outranks a pop so the newest address is never lost.
    if (push_i && (push_addr_i != cmp_addr_i)) begin
      valid_d = 1'b1;
      addr_d  = push_addr_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
endmodule

// File: rtl/xsleena_gfx_rom_responder.sv
// Background-layer graphics ROM responder: turns single-cycle layer requests
// into SDRAM request/acknowledge reads, short-circuits repeats of the last
// completed address, keeps one newest-wins pending request, and abandons an
// access that stalls for TIMEOUT clocks (sticky rom_err).
// Ports: clk, RESET (async active-high), bus (slave side of the layer/SDRAM
// bundle, see xsleena_gfx_rom_responder_if).
module xsleena_gfx_rom_responder
  import xsleena_rom_pkg::*;
#(
  parameter int                SDR_AW    = 24,
  parameter logic [SDR_AW-1:0] BASE_WORD = '0,
  parameter int                TIMEOUT   = ROM_TIMEOUT_DEF
) (
  input logic                               clk,
  input logic                               RESET,
  xsleena_gfx_rom_responder_if.slave        bus
);
  localparam logic [ROM_TMO_W-1:0] TMO_LAST = ROM_TMO_W'(TIMEOUT - 1);

  rom_rsp_state_t        state_q, state_d;
  logic [ROM_ADDR_W-1:0] addr_q, addr_d;
  logic [ROM_ADDR_W-1:0] last_q, last_d;
  logic [ROM_DATA_W-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  hit_ok_q, hit_ok_d;
  logic [ROM_TMO_W-1:0]  tmo_q, tmo_d;
  logic [ROM_ADDR_W-1:0] cand_addr;
  logic                  slot_push, slot_pop, slot_valid;
  logic [ROM_ADDR_W-1:0] slot_addr;

  xsleena_req_slot #(.AW(ROM_ADDR_W)) u_slot (
    .clk         (clk),
    .rst         (RESET),
    .push_i      (slot_push),
    .push_addr_i (bus.req_ROM_addr),
    .cmp_addr_i  (addr_q),
    .pop_i       (slot_pop),
    .valid_o     (slot_valid),
    .addr_o      (slot_addr)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    last_d    = last_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    hit_ok_d  = hit_ok_q;
    tmo_d     = tmo_q + 1'b1;
    cand_addr = '0;
    slot_push = 1'b0;
    slot_pop  = 1'b0;

    case (state_q)
      RSP_IDLE: begin
        // A live request beats a slot entry left over from a timeout.
        if (bus.ROM_req || slot_valid) begin
          cand_addr = bus.ROM_req ? bus.req_ROM_addr : slot_addr;
          slot_pop  = slot_valid;
          if (hit_ok_q && (cand_addr == last_q)) begin
            valid_d = 1'b1;
          end else begin
            addr_d  = cand_addr;
            state_d = RSP_ISSUE;
          end
        end
      end
      RSP_ISSUE: begin
        slot_push = bus.ROM_req;
        if (bus.sdr_ack) begin
          if (bus.sdr_rdy) begin
            data_d   = bus.sdr_dout;
            valid_d  = 1'b1;
            last_d   = addr_q;
            hit_ok_d = 1'b1;
            state_d  = RSP_DONE;
          end else begin
            state_d = RSP_WAIT;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d    = 1'b1;
          hit_ok_d = 1'b0;
          state_d  = RSP_IDLE;
        end
      end
      RSP_WAIT: begin
        slot_push = bus.ROM_req;
        if (bus.sdr_rdy) begin
          data_d   = bus.sdr_dout;
          valid_d  = 1'b1;
          last_d   = addr_q;
          hit_ok_d = 1'b1;
          state_d  = RSP_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d    = 1'b1;
          hit_ok_d = 1'b0;
          state_d  = RSP_IDLE;
        end
      end
      RSP_DONE: begin
        // A request arriving now is taken straight into ISSUE instead of
        // passing through the slot; it still supersedes any older entry.
        if (bus.ROM_req && (bus.req_ROM_addr != addr_q)) begin
          addr_d   = bus.req_ROM_addr;
          slot_pop = slot_valid;
          state_d  = RSP_ISSUE;
        end else if (slot_valid) begin
          addr_d   = slot_addr;
          slot_pop = 1'b1;
          state_d  = RSP_ISSUE;
        end else begin
          state_d = RSP_IDLE;
        end
      end
      default: state_d = RSP_IDLE;
    endcase

    if (state_d != state_q) tmo_d = '0;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q  <= RSP_IDLE;
      addr_q   <= '0;
      last_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      hit_ok_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      hit_ok_q <= hit_ok_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.ROM_data  = data_q;
  assign bus.rom_valid = valid_q;
  assign bus.rom_err   = err_q;
  assign bus.rom_busy  = (state_q != RSP_IDLE) || slot_valid;
  assign bus.sdr_req   = (state_q == RSP_ISSUE);
  assign bus.sdr_addr  = (state_q == RSP_ISSUE) ? (BASE_WORD + SDR_AW'(addr_q)) : '0;
endmodule

// File: tb/tb_xsleena_gfx_rom_responder.sv
module tb_xsleena_gfx_rom_responder;
  logic clk;
  logic RESET;

  int unsigned n_chk;
  int unsigned n_bad;

  xsleena_gfx_rom_responder_if #(.SDR_AW(24)) bus0 ();
  xsleena_gfx_rom_responder_if #(.SDR_AW(24)) bus1 ();

  xsleena_gfx_rom_responder #(
    .SDR_AW(24), .BASE_WORD(24'h000000), .TIMEOUT(31)
  ) u_dut0 (.clk(clk), .RESET(RESET), .bus(bus0));

  xsleena_gfx_rom_responder #(
    .SDR_AW(24), .BASE_WORD(24'h100000), .TIMEOUT(31)
  ) u_dut1 (.clk(clk), .RESET(RESET), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Activity logs sampled mid-cycle.
  logic [23:0] rd_log [64];
  int unsigned rd_cnt;
  int unsigned vld_cnt;
  int unsigned req1_cnt;

  initial begin
    rd_cnt = 0; vld_cnt = 0; req1_cnt = 0;
  end

  always @(negedge clk) begin
    if (!RESET) begin
      if (bus0.sdr_req && bus0.sdr_ack) begin
        if (rd_cnt < 64) rd_log[rd_cnt] = bus0.sdr_addr;
        rd_cnt = rd_cnt + 1;
      end
      if (bus0.rom_valid) vld_cnt = vld_cnt + 1;
      if (bus1.sdr_req) req1_cnt = req1_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned base_rd;
  int unsigned base_vld;
  int unsigned req_len;

  initial begin
    n_chk = 0; n_bad = 0;
    RESET = 1'b1;
    bus0.ROM_req = 1'b0; bus0.req_ROM_addr = '0;
    bus0.sdr_ack = 1'b0; bus0.sdr_rdy = 1'b0; bus0.sdr_dout = '0;
    bus1.ROM_req = 1'b0; bus1.req_ROM_addr = '0;
    bus1.sdr_ack = 1'b0; bus1.sdr_rdy = 1'b0; bus1.sdr_dout = '0;
    tick(); tick();

    chk("rst_data",  bus0.ROM_data,  16'h0000);
    chk("rst_valid", bus0.rom_valid, 1'b0);
    chk("rst_busy",  bus0.rom_busy,  1'b0);
    chk("rst_err",   bus0.rom_err,   1'b0);
    chk("rst_req",   bus0.sdr_req,   1'b0);
    chk("rst_addr",  bus0.sdr_addr,  24'h0);
    chk("rst_addr1", bus1.sdr_addr,  24'h0);
    RESET = 1'b0;
    tick();

    // Single miss
    bus0.ROM_req = 1'b1; bus0.req_ROM_addr = 17'h01234;
    tick();
    bus0.ROM_req = 1'b0;
    chk("miss_req",  bus0.sdr_req,  1'b1);
    chk("miss_addr", bus0.sdr_addr, 24'h001234);
    chk("miss_busy", bus0.rom_busy, 1'b1);
    bus0.sdr_ack = 1'b1;
    tick();
    bus0.sdr_ack = 1'b0;
    chk("miss_req_drop", bus0.sdr_req, 1'b0);
    tick();
    bus0.sdr_rdy = 1'b1; bus0.sdr_dout = 16'hA55A;
    tick();
    bus0.sdr_rdy = 1'b0;
    chk("miss_valid", bus0.rom_valid, 1'b1);
    chk("miss_data",  bus0.ROM_data,  16'hA55A);
    tick();
    chk("miss_valid_end", bus0.rom_valid, 1'b0);
    chk("miss_busy_end",  bus0.rom_busy,  1'b0);

    // Repeat hit
    base_rd = rd_cnt;
    bus0.ROM_req = 1'b1; bus0.req_ROM_addr = 17'h01234;
    tick();
    bus0.ROM_req = 1'b0;
    chk("hit_valid", bus0.rom_valid, 1'b1);
    chk("hit_noreq", bus0.sdr_req,   1'b0);
    chk("hit_data",  bus0.ROM_data,  16'hA55A);
    tick();
    chk("hit_valid_end", bus0.rom_valid, 1'b0);
    chk("hit_noread",    rd_cnt - base_rd, 0);

    // Overwrite while busy
    base_rd = rd_cnt;
    bus0.ROM_req = 1'b1; bus0.req_ROM_addr = 17'h00010;
    tick();
    chk("ow_addr0", bus0.sdr_addr, 24'h000010);
    bus0.req_ROM_addr = 17'h00020; bus0.sdr_ack = 1'b1;
    tick();
    bus0.req_ROM_addr = 17'h00030; bus0.sdr_ack = 1'b0;
    tick();
    bus0.ROM_req = 1'b0;
    repeat (4) tick();
    bus0.sdr_rdy = 1'b1; bus0.sdr_dout = 16'h1111;
    tick();
    bus0.sdr_rdy = 1'b0;
    chk("ow_valid0", bus0.rom_valid, 1'b1);
    chk("ow_data0",  bus0.ROM_data,  16'h1111);
    chk("ow_gap",    bus0.sdr_req,   1'b0);
    chk("ow_busy",   bus0.rom_busy,  1'b1);
    tick();
    chk("ow_req1",  bus0.sdr_req,  1'b1);
    chk("ow_addr1", bus0.sdr_addr, 24'h000030);
    bus0.sdr_ack = 1'b1;
    tick();
    bus0.sdr_ack = 1'b0;
    repeat (4) tick();
    bus0.sdr_rdy = 1'b1; bus0.sdr_dout = 16'h3333;
    tick();
    bus0.sdr_rdy = 1'b0;
    chk("ow_data1", bus0.ROM_data, 16'h3333);
    tick();
    chk("ow_busy_end", bus0.rom_busy, 1'b0);
    chk("ow_nreads",   rd_cnt - base_rd, 2);
    chk("ow_rd0",      rd_log[base_rd],     24'h000010);
    chk("ow_rd1",      rd_log[base_rd + 1], 24'h000030);

    // Same-clock ack/rdy with non-zero base
    bus1.ROM_req = 1'b1; bus1.req_ROM_addr = 17'h1FFFF;
    tick();
    bus1.ROM_req = 1'b0;
    chk("sc_req",  bus1.sdr_req,  1'b1);
    chk("sc_addr", bus1.sdr_addr, 24'h11FFFF);
    bus1.sdr_ack = 1'b1; bus1.sdr_rdy = 1'b1; bus1.sdr_dout = 16'hBEEF;
    tick();
    bus1.sdr_ack = 1'b0; bus1.sdr_rdy = 1'b0;
    chk("sc_valid", bus1.rom_valid, 1'b1);
    chk("sc_data",  bus1.ROM_data,  16'hBEEF);
    chk("sc_req_drop", bus1.sdr_req, 1'b0);
    tick();
    chk("sc_busy_end", bus1.rom_busy, 1'b0);
    chk("sc_req_cycles", req1_cnt, 1);

    // Timeout
    base_vld = vld_cnt;
    bus0.ROM_req = 1'b1; bus0.req_ROM_addr = 17'h00555;
    tick();
    bus0.ROM_req = 1'b0;
    req_len = 0;
    while (bus0.sdr_req && req_len < 40) begin
      req_len = req_len + 1;
      tick();
    end
    chk("to_len",   req_len, 31);
    chk("to_err",   bus0.rom_err,   1'b1);
    chk("to_data",  bus0.ROM_data,  16'h3333);
    chk("to_nvld",  vld_cnt - base_vld, 0);
    chk("to_busy",  bus0.rom_busy,  1'b0);
    // Last completed address no longer short-circuits after a timeout
    bus0.ROM_req = 1'b1; bus0.req_ROM_addr = 17'h00030;
    tick();
    bus0.ROM_req = 1'b0;
    chk("to_nohit_req", bus0.sdr_req,  1'b1);
    chk("to_nohit_adr", bus0.sdr_addr, 24'h000030);
    bus0.sdr_ack = 1'b1; bus0.sdr_rdy = 1'b1; bus0.sdr_dout = 16'h3030;
    tick();
    bus0.sdr_ack = 1'b0; bus0.sdr_rdy = 1'b0;
    chk("to_nohit_data", bus0.ROM_data, 16'h3030);
    tick();
    bus0.ROM_req = 1'b1; bus0.req_ROM_addr = 17'h00555;
    tick();
    bus0.ROM_req = 1'b0;
    chk("to_retry_req", bus0.sdr_req,  1'b1);
    chk("to_retry_adr", bus0.sdr_addr, 24'h000555);
    bus0.sdr_ack = 1'b1; bus0.sdr_rdy = 1'b1; bus0.sdr_dout = 16'h5555;
    tick();
    bus0.sdr_ack = 1'b0; bus0.sdr_rdy = 1'b0;
    chk("to_retry_data", bus0.ROM_data, 16'h5555);
    tick();
    chk("to_err_sticky", bus0.rom_err, 1'b1);

    // Reset mid-WAIT
    bus0.ROM_req = 1'b1; bus0.req_ROM_addr = 17'h00777;
    tick();
    bus0.ROM_req = 1'b0;
    bus0.sdr_ack = 1'b1;
    tick();
    bus0.sdr_ack = 1'b0;
    chk("rw_busy", bus0.rom_busy, 1'b1);
    RESET = 1'b1;
    #1;
    chk("rw_data",  bus0.ROM_data,  16'h0000);
    chk("rw_err",   bus0.rom_err,   1'b0);
    chk("rw_busy0", bus0.rom_busy,  1'b0);
    chk("rw_valid", bus0.rom_valid, 1'b0);
    chk("rw_req",   bus0.sdr_req,   1'b0);
    tick();
    RESET = 1'b0;
    bus0.sdr_rdy = 1'b1; bus0.sdr_dout = 16'hDEAD;
    tick();
    bus0.sdr_rdy = 1'b0;
    chk("rw_late_valid", bus0.rom_valid, 1'b0);
    chk("rw_late_data",  bus0.ROM_data,  16'h0000);
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
